// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_gen
// Description : 640x480 @ 60 Hz VGA timing generator. Divides the system
//               clock down to the pixel rate, walks the x/y raster counters,
//               and produces registered active-low hsync/vsync together with
//               video_on, a pixel strobe and an end-of-frame strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic       frame_tick,
    output logic [9:0] x,
    output logic [9:0] y
);

    localparam int c_h_total = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int c_v_total = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    // A divide-by-one still needs a one-bit counter that simply stays at zero.
    localparam int c_div_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
    localparam logic [9:0] c_h_last   = 10'(c_h_total - 1);
    localparam logic [9:0] c_v_last   = 10'(c_v_total - 1);
    localparam logic [9:0] c_h_disp   = 10'(H_DISPLAY);
    localparam logic [9:0] c_v_disp   = 10'(V_DISPLAY);
    localparam logic [9:0] c_hs_first = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] c_hs_last  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] c_vs_first = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] c_vs_last  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [c_div_w-1:0] r_div_cnt;
    logic [9:0]         r_x;
    logic [9:0]         r_y;
    logic               r_hsync;
    logic               r_vsync;
    logic               w_p_tick;
    logic               w_line_end;
    logic [9:0]         w_x_next;
    logic [9:0]         w_y_next;

    // The pixel strobe is decoded straight from the divider register.
    assign w_p_tick   = (r_div_cnt == c_div_last);
    assign w_line_end = w_p_tick && (r_x == c_h_last);

    // Pixel-rate divider: free-running 0..CLK_DIV-1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div_cnt <= '0;
        end else if (r_div_cnt == c_div_last) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // Next raster position; the sync decode looks at these so that the sync
    // outputs change on the same edge as the coordinates they describe.
    always_comb begin
        w_x_next = r_x;
        w_y_next = r_y;
        if (w_p_tick) begin
            w_x_next = (r_x == c_h_last) ? 10'd0 : r_x + 10'd1;
        end
        if (w_line_end) begin
            w_y_next = (r_y == c_v_last) ? 10'd0 : r_y + 10'd1;
        end
    end

    // Raster counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x <= 10'd0;
            r_y <= 10'd0;
        end else begin
            r_x <= w_x_next;
            r_y <= w_y_next;
        end
    end

    // Registered active-low sync pulses decoded from the next-state position.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
        end else begin
            r_hsync <= !((w_x_next >= c_hs_first) && (w_x_next <= c_hs_last));
            r_vsync <= !((w_y_next >= c_vs_first) && (w_y_next <= c_vs_last));
        end
    end

    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign x          = r_x;
    assign y          = r_y;
    assign p_tick     = w_p_tick;
    assign video_on   = (r_x < c_h_disp) && (r_y < c_v_disp);
    assign frame_tick = w_line_end && (r_y == c_v_last);

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_sync_gen
// Description : Directed self-checking bench for vga_sync_gen. A full-size
//               instance covers reset, pixel strobe and line timing; a
//               reduced-geometry instance (15 x 8 raster, 480 clk per frame)
//               covers frame-level behaviour and mid-frame reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_gen;

    logic       clk;
    logic       reset_n;

    logic       w_hsync, w_vsync, w_video_on, w_p_tick, w_frame_tick;
    logic [9:0] w_x, w_y;

    logic       s_hsync, s_vsync, s_video_on, s_p_tick, s_frame_tick;
    logic [9:0] s_x, s_y;

    int total = 0;
    int bad   = 0;
    int cur   = 0;   // rising edges since the most recent reset release

    vga_sync_gen dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .hsync      (w_hsync),
        .vsync      (w_vsync),
        .video_on   (w_video_on),
        .p_tick     (w_p_tick),
        .frame_tick (w_frame_tick),
        .x          (w_x),
        .y          (w_y)
    );

    // Small raster: H 8+2+3+2 = 15 (hsync low x=10..12),
    //               V 4+1+2+1 = 8  (vsync low y=5..6); line 60 clk, frame 480 clk.
    vga_sync_gen #(
        .CLK_DIV   (4),
        .H_DISPLAY (8),
        .H_FRONT   (2),
        .H_SYNC    (3),
        .H_BACK    (2),
        .V_DISPLAY (4),
        .V_FRONT   (1),
        .V_SYNC    (2),
        .V_BACK    (1)
    ) dut_s (
        .clk        (clk),
        .reset_n    (reset_n),
        .hsync      (s_hsync),
        .vsync      (s_vsync),
        .video_on   (s_video_on),
        .p_tick     (s_p_tick),
        .frame_tick (s_frame_tick),
        .x          (s_x),
        .y          (s_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic goto(input int target);
        repeat (target - cur) @(negedge clk);
        cur = target;
    endtask

    // Called right at the negedge where reset_n was released (cycle 0).
    task automatic strobe_seq(input string tag);
        for (int c = 0; c < 16; c++) begin
            #1;
            chk({tag, " p_tick"},   32'(w_p_tick), 32'((c % 4) == 3));
            chk({tag, " x"},        32'(w_x),      32'(c / 4));
            chk({tag, " s_p_tick"}, 32'(s_p_tick), 32'((c % 4) == 3));
            chk({tag, " s_x"},      32'(s_x),      32'(c / 4));
            chk({tag, " s_hsync"},  32'(s_hsync),  32'd1);
            @(negedge clk);
        end
        cur = 16;
    endtask

    initial begin
        int vs_low, hs_low, vid, ft, refr, ft_first, ft_last, vid_bad;

        // ---------------- reset values ----------------
        reset_n = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst x",          32'(w_x),          32'd0);
        chk("rst y",          32'(w_y),          32'd0);
        chk("rst hsync",      32'(w_hsync),      32'd1);
        chk("rst vsync",      32'(w_vsync),      32'd1);
        chk("rst p_tick",     32'(w_p_tick),     32'd0);
        chk("rst frame_tick", 32'(w_frame_tick), 32'd0);
        chk("rst video_on",   32'(w_video_on),   32'd1);

        // ---------------- pixel strobe ----------------
        reset_n = 1'b1;
        strobe_seq("strobe");

        // ---------------- horizontal timing (full size) ----------------
        goto(2559);
        chk("h x639",       32'(w_x),        32'd639);
        chk("h vid639",     32'(w_video_on), 32'd1);
        goto(2560);
        chk("h x640",       32'(w_x),        32'd640);
        chk("h vid640",     32'(w_video_on), 32'd0);
        chk("h hs640",      32'(w_hsync),    32'd1);
        goto(2623);
        chk("h hs655",      32'(w_hsync),    32'd1);
        goto(2624);
        chk("h x656",       32'(w_x),        32'd656);
        chk("h hs656",      32'(w_hsync),    32'd0);
        goto(3007);
        chk("h hs751",      32'(w_hsync),    32'd0);
        goto(3008);
        chk("h x752",       32'(w_x),        32'd752);
        chk("h hs752",      32'(w_hsync),    32'd1);
        goto(3199);
        chk("h x799",       32'(w_x),        32'd799);
        chk("h y line0",    32'(w_y),        32'd0);
        chk("h p_tick799",  32'(w_p_tick),   32'd1);
        chk("h ftick799",   32'(w_frame_tick), 32'd0);
        goto(3200);
        chk("h wrap x",     32'(w_x),        32'd0);
        chk("h wrap y",     32'(w_y),        32'd1);
        chk("h wrap vid",   32'(w_video_on), 32'd1);
        chk("h wrap vs",    32'(w_vsync),    32'd1);

        // ---------------- frame timing (small raster, frame base 3360) ------
        goto(3359);
        chk("v last x",     32'(s_x),          32'd14);
        chk("v last y",     32'(s_y),          32'd7);
        chk("v ftick",      32'(s_frame_tick), 32'd1);
        goto(3360);
        chk("v start x",    32'(s_x),          32'd0);
        chk("v start y",    32'(s_y),          32'd0);
        chk("v ftick off",  32'(s_frame_tick), 32'd0);
        goto(3399);
        chk("v hs x9",      32'(s_hsync),      32'd1);
        goto(3400);
        chk("v x10",        32'(s_x),          32'd10);
        chk("v hs x10",     32'(s_hsync),      32'd0);
        goto(3412);
        chk("v hs x13",     32'(s_hsync),      32'd1);
        goto(3560);
        chk("v vid y3x5",   32'(s_video_on),   32'd1);
        goto(3599);
        chk("v vid y3x14",  32'(s_video_on),   32'd0);
        goto(3600);
        chk("v y4",         32'(s_y),          32'd4);
        chk("v vid y4x0",   32'(s_video_on),   32'd0);
        goto(3659);
        chk("v vs y4",      32'(s_vsync),      32'd1);
        goto(3660);
        chk("v y5",         32'(s_y),          32'd5);
        chk("v vs y5",      32'(s_vsync),      32'd0);
        goto(3779);
        chk("v vs y6",      32'(s_vsync),      32'd0);
        goto(3780);
        chk("v y7",         32'(s_y),          32'd7);
        chk("v vs y7",      32'(s_vsync),      32'd1);

        // Two whole frames starting at cycle 3840.
        goto(3840);
        vs_low = 0; hs_low = 0; vid = 0; ft = 0; refr = 0;
        ft_first = -1; ft_last = -1; vid_bad = 0;
        for (int c = 0; c < 960; c++) begin
            if (!s_vsync)   vs_low++;
            if (!s_hsync)   hs_low++;
            if (s_video_on) vid++;
            if (s_frame_tick) begin
                ft++;
                if (ft_first < 0) ft_first = cur;
                ft_last = cur;
            end
            if (s_y == 10'd5 && s_x == 10'd0) refr++;
            if (s_y >= 10'd4 && s_video_on) vid_bad++;
            @(negedge clk);
            cur++;
        end
        chk("f vsync low clk",  32'(vs_low),   32'd240);
        chk("f hsync low clk",  32'(hs_low),   32'd192);
        chk("f video_on clk",   32'(vid),      32'd256);
        chk("f vid blank rows", 32'(vid_bad),  32'd0);
        chk("f ftick count",    32'(ft),       32'd2);
        chk("f ftick first",    32'(ft_first), 32'd4319);
        chk("f ftick period",   32'(ft_last - ft_first), 32'd480);
        chk("f refresh clk",    32'(refr),     32'd8);
        chk("f big x",          32'(w_x),      32'd400);
        chk("f big y",          32'(w_y),      32'd1);

        // ---------------- mid-operation asynchronous reset ----------------
        goto(5145);
        chk("m pre x",      32'(s_x),     32'd11);
        chk("m pre y",      32'(s_y),     32'd5);
        chk("m pre hs",     32'(s_hsync), 32'd0);
        chk("m pre vs",     32'(s_vsync), 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("m async hs",   32'(s_hsync),    32'd1);
        chk("m async vs",   32'(s_vsync),    32'd1);
        chk("m async x",    32'(s_x),        32'd0);
        chk("m async y",    32'(s_y),        32'd0);
        chk("m async pt",   32'(s_p_tick),   32'd0);
        chk("m async vid",  32'(s_video_on), 32'd1);
        chk("m async bx",   32'(w_x),        32'd0);
        chk("m async by",   32'(w_y),        32'd0);
        repeat (3) @(negedge clk);
        chk("m hold x",     32'(s_x),        32'd0);
        chk("m hold pt",    32'(s_p_tick),   32'd0);
        reset_n = 1'b1;
        cur = 0;
        strobe_seq("restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_sync_gen.md
# vga_sync_gen

Generates 640x480 @ 60 Hz VGA timing from the 100 MHz board clock. It is the producer side of the pixel interface consumed by the graphics and text blocks, which read x, y and video_on and return RGB. It drives hsync and vsync to the connector and exposes the pixel and frame strobes. All downstream game logic, including the refresh tick at y == 481, x == 0, depends on its counter sequence.

## Interface
Parameters:
- CLK_DIV, 4: clk cycles per pixel; 100 MHz / 4 = 25 MHz pixel rate.
- H_DISPLAY, 640: visible pixels per line.
- H_FRONT, 16: right border (front porch) in pixels.
- H_SYNC, 96: horizontal retrace width in pixels.
- H_BACK, 48: left border (back porch) in pixels.
- V_DISPLAY, 480: visible lines.
- V_FRONT, 10: bottom border in lines.
- V_SYNC, 2: vertical retrace width in lines.
- V_BACK, 33: top border in lines.

Derived values (not overridable):
- H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK = 800.
- V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK = 525.

Ports:
- clk, input, 1: 100 MHz system clock; all state changes on its rising edge.
- reset_n, input, 1: reset, asynchronous, active-low.
- hsync, output, 1: horizontal sync, active low, registered.
- vsync, output, 1: vertical sync, active low, registered.
- video_on, output, 1: high while the current pixel is visible (x < H_DISPLAY and y < V_DISPLAY).
- p_tick, output, 1: one-clk strobe each pixel period.
- frame_tick, output, 1: one-clk strobe on the last pixel of each frame.
- x, output, 10: current pixel column, 0..H_TOTAL-1.
- y, output, 10: current line, 0..V_TOTAL-1.

## Operation
- Divider: div_cnt has width $clog2(CLK_DIV). It counts 0..CLK_DIV-1 on every clk and wraps to 0. p_tick = (div_cnt == CLK_DIV-1), decoded from the register.
- Horizontal counter x advances only in cycles where p_tick = 1.
  - x == H_TOTAL-1 -> x = 0; otherwise x + 1.
- Vertical counter y advances only when p_tick = 1 and x == H_TOTAL-1.
  - y == V_TOTAL-1 -> y = 0; otherwise y + 1.
- Sync decode, evaluated on the next-state counter values and registered on the same edge as the counters:
  - hsync = 0 iff H_DISPLAY+H_FRONT <= x <= H_DISPLAY+H_FRONT+H_SYNC-1, i.e. 656..751.
  - vsync = 0 iff V_DISPLAY+V_FRONT <= y <= V_DISPLAY+V_FRONT+V_SYNC-1, i.e. 490..491.
- video_on is combinational from the x/y registers. It is low in every blanking pixel, including the whole of lines 480..524.
- frame_tick = p_tick & (x == H_TOTAL-1) & (y == V_TOTAL-1). It is high for exactly one clk per frame.
- No other inputs. The block is free-running after reset.

## Timing
- Reset (reset_n = 0, asynchronous) forces: div_cnt=0, x=0, y=0, hsync=1, vsync=1. As a result p_tick=0, frame_tick=0 and video_on=1 while in reset.
- First p_tick: the CLK_DIV-th rising edge after reset_n deasserts has div_cnt == CLK_DIV-1, so p_tick is high in clk cycle 3 (0-based).
  - x becomes 1 on the edge ending that cycle.
- Holding periods (CLK_DIV = 4):
  - x holds for exactly 4 clk.
  - A line is 3200 clk.
  - A frame is 1,680,000 clk.
- hsync and vsync change on the same edge as x/y. There is no pipeline offset between the sync outputs and the coordinates.
- Wrap-around: the edge that takes x from 799 to 0 also takes y to y+1, or to 0 when y was 524. Both changes happen in the same clk.
- The sequence passes through (x=0, y=481) once per frame, for one pixel period of 4 clk.
- Reset asserted mid-frame: outputs take their reset values immediately, without waiting for a clk edge. Counting restarts from div_cnt=0 after release. No partial sync pulse may be extended.
- CLK_DIV = 1: p_tick is constantly 1, and the counters advance every clk.

## Test plan
- Reset values: hold reset_n = 0 for 10 clk -> x=0, y=0, hsync=1, vsync=1, p_tick=0, frame_tick=0, video_on=1.
- Pixel strobe: release reset -> p_tick high in clk cycles 3, 7, 11, … and low in all others. x = 0,1,2 at cycles 0–3, 4–7, 8–11.
- Horizontal timing over one line:
  - hsync falls when x becomes 656 and rises when x becomes 752, giving a 384-clk low pulse.
  - video_on falls when x becomes 640.
  - x wraps 799 -> 0 with y incrementing on the same edge.
- Vertical timing over a full frame:
  - vsync is low only for y = 490..491, i.e. 6400 clk.
  - video_on stays 0 for y >= 480.
  - frame_tick pulses once, when x=799 and y=524.
  - The next frame_tick comes 1,680,000 clk later.
- Refresh point: across two frames, (y=481, x=0) occurs exactly once per frame, lasting 4 clk.
- Mid-operation reset: assert reset_n = 0 asynchronously at x=700, y=490, between clk edges -> hsync=1, vsync=1, x=0, y=0 before the next edge. After release, the strobe sequence repeats exactly as in the pixel strobe test.
